// File: rtl/adc_sample_capture.sv
// Serial ADC front end: runs one SPI-style conversion frame per START and deserialises the
// 12-bit sample. The sample is presented as two's complement with a one-cycle VALID strobe.
module adc_sample_capture #(
    parameter int CLK_DIV       = 4,
    parameter int FRAME_BITS    = 16,
    parameter int LEAD_BITS     = 4,
    parameter int OFFSET_BINARY = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        SDATA,
    output logic        SCLK,
    output logic        CS_N,
    output logic        BUSY,
    output logic [11:0] SAMPLE,
    output logic        VALID
);

    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(FRAME_BITS) + 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS);
    localparam logic [BW-1:0] DATA_FIRST = BW'(LEAD_BITS);
    localparam logic [BW-1:0] DATA_END   = BW'(LEAD_BITS + 12);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [11:0]   shreg_q, shreg_d;
    logic [11:0]   sample_q, sample_d;
    logic          sclk_q, sclk_d;
    logic          csn_q, csn_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          divDone;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            sample_q <= '0;
            sclk_q   <= 1'b1;
            csn_q    <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            sample_q <= sample_d;
            sclk_q   <= sclk_d;
            csn_q    <= csn_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign divDone = (div_q == DIV_LAST);

    // SCLK toggles whenever the divider expires; the low->high toggle is the capture point,
    // since the ADC moved SDATA on the preceding falling edge.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        sample_d = sample_q;
        sclk_d   = sclk_q;
        csn_d    = csn_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    csn_d    = 1'b0;
                    busy_d   = 1'b1;
                    div_d    = '0;
                    bitcnt_d = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (divDone) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SHIFT: begin
                if (!divDone) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d   = 1'b1;
                        bitcnt_d = bitcnt_q + BW'(1);
                        if (bitcnt_q >= DATA_FIRST && bitcnt_q < DATA_END) begin
                            shreg_d = {shreg_q[10:0], SDATA};
                        end
                    end else if (bitcnt_q == BIT_LAST) begin
                        csn_d    = 1'b1;
                        busy_d   = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = IDLE;
                        sample_d = (OFFSET_BINARY != 0) ? {~shreg_q[11], shreg_q[10:0]} : shreg_q;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign SCLK   = sclk_q;
    assign CS_N   = csn_q;
    assign BUSY   = busy_q;
    assign SAMPLE = sample_q;
    assign VALID  = valid_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Bench for adc_sample_capture: three differently parameterised instances, each fed by a
// behavioural ADC that shifts a frame out on SCLK falling edges.
module tb_adc_sample_capture;

    logic        clk = 1'b0;
    logic        resetN;
    logic [2:0]  start = 3'b000;
    logic [2:0]  sdata = 3'b000;
    logic [2:0]  sclk, csn, busy, valid;
    logic [11:0] sample [3];

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    logic        frameBits [3][32];
    logic [11:0] lastExp [3];
    int rises [3];
    int idx [3];
    int lastRise [3];
    int gapMin [3];
    int gapMax [3];
    int idleToggles = 0;
    int csnEdgeBad = 0;
    int mcyc = 0;
    logic [2:0] prevSclk = 3'b111;
    logic [2:0] prevCsn = 3'b111;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_sample_capture #(.CLK_DIV(4), .FRAME_BITS(16), .LEAD_BITS(4), .OFFSET_BINARY(1)) dut0 (
        .CLK(clk), .RESET_N(resetN), .START(start[0]), .SDATA(sdata[0]), .SCLK(sclk[0]),
        .CS_N(csn[0]), .BUSY(busy[0]), .SAMPLE(sample[0]), .VALID(valid[0]));

    adc_sample_capture #(.CLK_DIV(1), .FRAME_BITS(16), .LEAD_BITS(4), .OFFSET_BINARY(0)) dut1 (
        .CLK(clk), .RESET_N(resetN), .START(start[1]), .SDATA(sdata[1]), .SCLK(sclk[1]),
        .CS_N(csn[1]), .BUSY(busy[1]), .SAMPLE(sample[1]), .VALID(valid[1]));

    adc_sample_capture #(.CLK_DIV(2), .FRAME_BITS(20), .LEAD_BITS(4), .OFFSET_BINARY(0)) dut2 (
        .CLK(clk), .RESET_N(resetN), .START(start[2]), .SDATA(sdata[2]), .SCLK(sclk[2]),
        .CS_N(csn[2]), .BUSY(busy[2]), .SAMPLE(sample[2]), .VALID(valid[2]));

    function automatic int cdOf(input int i);
        case (i)
            0: return 4;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int fbOf(input int i);
        return (i == 2) ? 20 : 16;
    endfunction

    function automatic int leadOf(input int i);
        return (i >= 0) ? 4 : 0;
    endfunction

    function automatic bit obOf(input int i);
        return (i == 0);
    endfunction

    // Offset binary means the code minus half scale; otherwise the code is already signed.
    function automatic logic [11:0] expSample(input int i, input logic [11:0] raw);
        if (obOf(i)) return 12'(int'(raw) - 2048);
        return raw;
    endfunction

    // ADC model and SCLK observer, evaluated just after every clock edge.
    always @(posedge clk) begin
        #1;
        mcyc++;
        for (int i = 0; i < 3; i++) begin
            if (prevCsn[i] !== csn[i] && sclk[i] !== 1'b1) csnEdgeBad++;
            if (prevCsn[i] === 1'b1 && csn[i] === 1'b0) begin
                idx[i] = 0;
                rises[i] = 0;
                gapMin[i] = 100000;
                gapMax[i] = 0;
            end
            if (prevSclk[i] === 1'b0 && sclk[i] === 1'b1) begin
                if (csn[i] === 1'b1) idleToggles++;
                if (rises[i] > 0) begin
                    if (mcyc - lastRise[i] < gapMin[i]) gapMin[i] = mcyc - lastRise[i];
                    if (mcyc - lastRise[i] > gapMax[i]) gapMax[i] = mcyc - lastRise[i];
                end
                lastRise[i] = mcyc;
                rises[i]++;
            end
            if (prevSclk[i] === 1'b1 && sclk[i] === 1'b0) begin
                if (csn[i] === 1'b1) idleToggles++;
                else if (idx[i] < 32) begin
                    sdata[i] = frameBits[i][idx[i]];
                    idx[i]++;
                end
            end
            prevSclk[i] = sclk[i];
            prevCsn[i] = csn[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic buildFrame(input int i, input logic [11:0] raw, input logic leadFill,
                              input logic trailFill);
        for (int b = 0; b < 32; b++) begin
            if (b < leadOf(i)) frameBits[i][b] = leadFill;
            else if (b < leadOf(i) + 12) frameBits[i][b] = raw[11 - (b - leadOf(i))];
            else frameBits[i][b] = trailFill;
        end
    endtask

    // Called on a falling clock edge; returns on the falling edge where VALID is seen.
    task automatic applyStimulus(input int i, input logic [11:0] raw, input logic leadFill,
                                 input logic trailFill, input bit holdStart, output int startCyc);
        int k;
        int lat;
        bit seen;
        logic [11:0] exp;
        buildFrame(i, raw, leadFill, trailFill);
        exp = expSample(i, raw);
        lat = (2 * fbOf(i) + 1) * cdOf(i);
        start[i] = 1'b1;
        @(negedge clk);
        startCyc = cyc;
        if (!holdStart) start[i] = 1'b0;
        checkOutput($sformatf("busy_after_start%0d", i), 32'(busy[i]), 32'd1);
        checkOutput($sformatf("valid_one_cycle%0d", i), 32'(valid[i]), 32'd0);
        checkOutput($sformatf("sample_hold%0d", i), 32'(sample[i]), 32'(lastExp[i]));
        k = 0;
        seen = 1'b0;
        while (!seen && k < 4 * lat + 20) begin
            if (valid[i] === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        checkOutput($sformatf("valid_seen%0d", i), 32'(seen), 32'd1);
        checkOutput($sformatf("latency%0d", i), 32'(k), 32'(lat));
        checkOutput($sformatf("sample%0d", i), 32'(sample[i]), 32'(exp));
        checkOutput($sformatf("busy_at_valid%0d", i), 32'(busy[i]), 32'd0);
        checkOutput($sformatf("csn_at_valid%0d", i), 32'(csn[i]), 32'd1);
        checkOutput($sformatf("sclk_at_valid%0d", i), 32'(sclk[i]), 32'd1);
        checkOutput($sformatf("rising_edges%0d", i), 32'(rises[i]), 32'(fbOf(i)));
        checkOutput($sformatf("sclk_gap_min%0d", i), 32'(gapMin[i]), 32'(2 * cdOf(i)));
        checkOutput($sformatf("sclk_gap_max%0d", i), 32'(gapMax[i]), 32'(2 * cdOf(i)));
        lastExp[i] = exp;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s1;
        int s2;
        int k;
        logic [11:0] r;

        for (int i = 0; i < 3; i++) lastExp[i] = 12'h000;

        // Reset held with START high on every instance.
        resetN = 1'b1;
        start = 3'b111;
        #1 resetN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rst_sclk", 32'(sclk), 32'h7);
            checkOutput("rst_csn", 32'(csn), 32'h7);
            checkOutput("rst_busy", 32'(busy), 32'h0);
            checkOutput("rst_valid", 32'(valid), 32'h0);
            checkOutput("rst_sample", 32'(sample[0]), 32'h000);
        end
        checkOutput("rst_no_sclk_toggle", 32'(idleToggles), 32'd0);
        start = 3'b000;
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        // Three back-to-back offset-binary frames.
        applyStimulus(0, 12'h000, 1'b0, 1'b0, 1'b0, s1);
        applyStimulus(0, 12'hFFF, 1'b0, 1'b0, 1'b0, s1);
        applyStimulus(0, 12'h800, 1'b0, 1'b0, 1'b0, s1);
        repeat (3) @(negedge clk);

        // START held high across BUSY and the VALID cycle.
        applyStimulus(0, 12'h3C1, 1'b1, 1'b0, 1'b1, s1);
        applyStimulus(0, 12'hC3E, 1'b0, 1'b0, 1'b1, s2);
        start[0] = 1'b0;
        checkOutput("hold_period", 32'(s2 - s1), 32'd133);
        @(negedge clk);
        checkOutput("no_frame_after_drop", 32'(busy[0]), 32'd0);

        // Reset dropped in the middle of the 7th SCLK high phase.
        buildFrame(0, 12'h5A5, 1'b0, 1'b0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        k = 0;
        while (rises[0] != 7 && k < 400) begin
            @(negedge clk);
            k++;
        end
        checkOutput("mid_reached_7th_rise", 32'(rises[0]), 32'd7);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        checkOutput("mid_rst_sclk", 32'(sclk[0]), 32'd1);
        checkOutput("mid_rst_csn", 32'(csn[0]), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy[0]), 32'd0);
        checkOutput("mid_rst_sample", 32'(sample[0]), 32'h000);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("mid_rst_no_valid", 32'(valid[0]), 32'd0);
        end
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) lastExp[i] = 12'h000;
        @(negedge clk);
        checkOutput("post_rst_no_valid", 32'(valid[0]), 32'd0);
        applyStimulus(0, 12'h123, 1'b0, 1'b0, 1'b0, s1);

        // Two's complement pass-through, fast divider, leading and trailing junk.
        applyStimulus(1, 12'hA5C, 1'b0, 1'b0, 1'b0, s1);
        applyStimulus(1, 12'h001, 1'b1, 1'b1, 1'b0, s1);
        applyStimulus(2, 12'h001, 1'b1, 1'b1, 1'b0, s1);

        // Randomised frames across all instances.
        for (int n = 0; n < 9; n++) begin
            r = 12'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(n % 3, r, 1'($urandom), 1'($urandom), 1'b0, s1);
        end

        checkOutput("sclk_idle_when_csn_high", 32'(idleToggles), 32'd0);
        checkOutput("sclk_high_at_csn_change", 32'(csnEdgeBad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
- Serial ADC front end that sits directly upstream of the A-law compressor.
- Drives a 3-wire SPI-style ADC and deserialises one 12-bit sample per request.
- Converts the sample to 12-bit two's complement and holds it stable on SAMPLE, where it drives the compressor's 12-bit signed input.
- Pulses VALID for one cycle when a new sample is available.

Parameters:
- CLK_DIV, 4: SCLK half-period in CLK cycles; must be ≥1.
- FRAME_BITS, 16: SCLK rising edges per conversion frame; must be ≥ LEAD_BITS+12.
- LEAD_BITS, 4: leading bits per frame before the data MSB; these bits are discarded.
- OFFSET_BINARY, 1: 1 = ADC data is offset binary and is converted to two's complement; 0 = ADC data is already two's complement and passes through unchanged.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  conversion request; sampled only in IDLE.
- SDATA  input  1  serial data from ADC, MSB first; ADC updates it after SCLK falling edges.
- SCLK  output  1  serial clock to ADC; idles high.
- CS_N  output  1  ADC chip select, active low.
- BUSY  output  1  high while a frame is in progress.
- SAMPLE  output  12  last captured sample, two's complement.
- VALID  output  1  one-cycle pulse when SAMPLE updates.

Behaviour:
- Reset (async, RESET_N=0): state IDLE, SCLK=1, CS_N=1, BUSY=0, VALID=0, SAMPLE=0, shift register and all counters cleared. Outputs change immediately, not at the next clock edge.
- Reset mid-frame: the partial frame is discarded, no VALID is produced, and SAMPLE reads 0.
- All outputs are registered.
- States: IDLE, SETUP, SHIFT.
- IDLE: if START=1 at edge E0, then at E0 CS_N←0, BUSY←1, divider←0, bit count←0, state←SETUP. START=0 keeps the block in IDLE.
- SETUP: lasts CLK_DIV cycles. At edge E0+CLK_DIV, SCLK←0 and state←SHIFT.
- SHIFT: SCLK toggles every CLK_DIV cycles. The nth rising edge occurs at E0+2n·CLK_DIV.
  - In the CLK cycle that drives SCLK 0→1, shift SDATA in and increment the bit count.
  - Bits 1..LEAD_BITS are ignored.
  - Bits LEAD_BITS+1 .. LEAD_BITS+12 form raw[11:0], MSB first.
  - Remaining bits up to FRAME_BITS are ignored.
- Frame end: after the FRAME_BITS-th rising edge, SCLK stays high for CLK_DIV cycles. At edge E0+(2·FRAME_BITS+1)·CLK_DIV, in one edge:
  - CS_N←1, BUSY←0, VALID←1, state←IDLE.
  - SAMPLE←{~raw[11], raw[10:0]} if OFFSET_BINARY=1, else raw.
- Default latency: START edge to VALID edge is 132 cycles.
- VALID is high for exactly one cycle. SAMPLE holds until the next VALID or reset.
- START while BUSY=1, including the cycle in which VALID is asserted, is ignored and not queued.
- Earliest accepted restart is the edge after VALID, giving a minimum frame period of (2·FRAME_BITS+1)·CLK_DIV+1 cycles.
- SDATA is sampled directly in the rising-SCLK cycle; no synchroniser is used, since SCLK is generated locally.
- Divider width is clog2(CLK_DIV)+1. Bit counter width is clog2(FRAME_BITS)+1. Neither counter wraps inside a frame; both are cleared at frame start.
- CS_N low and SCLK activity occur only while BUSY=1. SCLK is high whenever CS_N changes.

Test Plan:
- Reset values: assert RESET_N=0 for 3 cycles with START=1 → SCLK=1, CS_N=1, BUSY=0, VALID=0, SAMPLE=0x000 throughout, and no SCLK toggles.
- Default parameters, ADC model returns offset-binary 0x000, then 0xFFF, then 0x800 in three back-to-back frames (START re-asserted the cycle after each VALID):
  - SAMPLE=0x800, then 0x7FF, then 0x000.
  - Each VALID occurs exactly 132 cycles after its START edge.
  - Each frame has 16 SCLK rising edges.
- Hold START=1 continuously, including during BUSY and the VALID cycle → no new frame during BUSY; the next frame starts on the edge after VALID; frame period is 133 cycles.
- Drop RESET_N low in the middle of the 7th SCLK high phase → SCLK, CS_N and BUSY return to reset values asynchronously with no VALID. A subsequent START with raw 0x123 (OFFSET_BINARY=1) yields SAMPLE=0x923.
- OFFSET_BINARY=0, CLK_DIV=1, FRAME_BITS=16, ADC raw 0xA5C → SAMPLE=0xA5C, VALID 33 cycles after START, SCLK period 2 cycles.
- Leading and trailing junk: ADC drives 1s on all LEAD_BITS and trailing bits with data 0x001 (OFFSET_BINARY=0) → SAMPLE=0x001.
